// File: rtl/apb_arb_pkg.sv
// Shared encodings and defaults for the APB requester arbiter.
// No logic; imported by the arbiter top and its round-robin picker.
package apb_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 3'b001;
    localparam arb_state_t ARB_XFER = 3'b010;
    localparam arb_state_t ARB_RESP = 3'b100;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int IW = $clog2(N);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[IW'((int'(i_ptr) + k) % N)]) begin
                w_found                             = 1'b1;
                o_gnt[IW'((int'(i_ptr) + k) % N)]   = 1'b1;
                o_idx                               = IW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master bridge among NUM_REQ requesters, round-robin, with slave-hang abort.
// Latency: zero-wait slave acks 4 cycles after req_valid; +1 per wait state.
// Backpressure: requesters hold req_valid until their one-cycle req_ack; one transfer at a time.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       req_err,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       transfer,
    output logic                       READ_WRITE,
    output logic [ADDR_W-1:0]          apb_write_paddr,
    output logic [ADDR_W-1:0]          apb_read_paddr,
    output logic [DATA_W-1:0]          apb_write_data,
    input  logic                       PENABLE,
    input  logic                       PREADY,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PSLVERR
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1) + 1;

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_gid;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CW-1:0]     r_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gidx;
    logic               w_xfer;
    logic               w_done;
    logic               w_abort;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx)
    );

    assign w_xfer  = (r_state == ARB_XFER);
    assign w_done  = w_xfer & PENABLE & PREADY;
    // Abort lands on the TIMEOUT-th wait cycle; counter holds the waits already seen.
    assign w_abort = (TIMEOUT != 0) && w_xfer && PENABLE && !PREADY
                     && (r_cnt == CW'(TIMEOUT - 1));

    // Dropping transfer in the completion cycle sends the bridge back to IDLE.
    assign transfer        = w_xfer & ~w_done & ~w_abort & ~PRESET;
    assign READ_WRITE      = r_rw;
    assign apb_write_paddr = r_addr;
    assign apb_read_paddr  = r_addr;
    assign apb_write_data  = r_wdata;
    assign grant_id        = r_gid;
    assign req_rdata       = r_rdata;
    assign req_err         = r_err;

    always_comb begin
        req_ack = '0;
        if (r_state == ARB_RESP) begin
            req_ack[r_gid] = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|w_gnt) begin
                        r_state <= ARB_XFER;
                        r_gid   <= w_gidx;
                        r_rw    <= req_rw[w_gidx];
                        r_addr  <= req_addr[w_gidx*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[w_gidx*DATA_W +: DATA_W];
                        r_cnt   <= '0;
                    end
                end
                ARB_XFER: begin
                    if (w_done) begin
                        r_rdata <= r_rw ? PRDATA : '0;
                        r_err   <= PSLVERR;
                        r_state <= ARB_RESP;
                    end else if (w_abort) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ARB_RESP;
                    end else if (PENABLE && !PREADY) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ARB_RESP: begin
                    r_ptr   <= IW'(wrap_inc(int'(r_gid), NUM_REQ));
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
